// File: rtl/hack_rom_loader_pkg.sv
// Shared types and constants for the Hack ROM serial loader.
// State encodings for the frame FSM and the UART receiver, plus frame helpers.
package hack_loader_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  function automatic logic in_frame(input loader_state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
           (s == ST_DATA_LO) || (s == ST_CHECK);
  endfunction

  // A word count is loadable when it is non-zero and fits the ROM depth.
  function automatic logic count_ok(input logic [15:0] count, input int unsigned addr_w);
    return (count != 16'd0) && ({1'b0, count} <= (17'd1 << addr_w));
  endfunction

endpackage

// File: rtl/hack_rom_loader_if.sv
// Received-byte stream from the UART receiver to the frame state machine.
interface hack_rom_loader_if;
  logic [7:0] data;
  logic       byte_valid;
  logic       frame_err;

  modport master (output data, byte_valid, frame_err);
  modport slave  (input  data, byte_valid, frame_err);
endinterface

// File: rtl/hack_rom_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, LSB-first shift.
// Emits one-cycle byte_valid or frame_err pulses the cycle after the stop sample.
module uart_rx
  import hack_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              rx_i,
  hack_rom_loader_if.master byte_if
);

  localparam int unsigned    CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        rx_state_q;
  logic             rx_meta_q;
  logic             rx_sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             byte_valid_q;
  logic             frame_err_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_state_q   <= RX_IDLE;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx_i;
      rx_sync_q    <= rx_meta_q;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      unique case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            cnt_q      <= HALF_LOAD;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (!rx_sync_q) begin
            cnt_q      <= FULL_LOAD;
            bit_q      <= '0;
            rx_state_q <= RX_DATA;
          end else begin
            rx_state_q <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            shift_q <= {rx_sync_q, shift_q[7:1]};
            cnt_q   <= FULL_LOAD;
            if (bit_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        RX_STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (rx_sync_q) begin
            data_q       <= shift_q;
            byte_valid_q <= 1'b1;
            rx_state_q   <= RX_IDLE;
          end else begin
            frame_err_q <= 1'b1;
            rx_state_q  <= RX_BREAK;
          end
        end
        // After a bad stop bit, wait for the line to idle before hunting a start bit.
        RX_BREAK: begin
          if (rx_sync_q) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_if.data       = data_q;
  assign byte_if.byte_valid = byte_valid_q;
  assign byte_if.frame_err  = frame_err_q;

endmodule

// File: rtl/hack_rom_loader.sv
// Serial bootloader for the Hack instruction ROM; holds the CPU during a load.
// Optional inter-byte timeout is built when HACK_LOADER_TIMEOUT_EN is defined.
//
// state      | meaning
// IDLE       | after reset, waiting for header 0xA5
// LEN_HI     | expecting COUNT high byte
// LEN_LO     | expecting COUNT low byte, range-checked
// DATA_HI    | expecting instruction high byte
// DATA_LO    | expecting instruction low byte, then write
// CHECK      | expecting checksum byte
// DONE       | image loaded, CPU released, header restarts
// ERROR      | image aborted, CPU held, header restarts
module hack_rom_loader
  import hack_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned TIMEOUT_CLKS = 5_000_000
) (
  input  logic              i_CLK,
  input  logic              i_RESET_n,
  input  logic              i_RX,
  output logic [ADDR_W-1:0] o_ROM_Address,
  output logic [15:0]       o_ROM_Data,
  output logic              o_ROM_Write_EN,
  output logic              o_CPU_Hold,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Error
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WORDS_ONE = (ADDR_W + 1)'(1);

  hack_rom_loader_if rx_bus ();

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i   (i_CLK),
    .rst_n_i (i_RESET_n),
    .rx_i    (i_RX),
    .byte_if (rx_bus.master)
  );

  loader_state_e     state_q;
  logic [7:0]        cnt_hi_q;
  logic [7:0]        data_hi_q;
  logic [7:0]        sum_q;
  logic [ADDR_W:0]   words_left_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       rom_data_q;
  logic              wr_q;
  logic              hold_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [15:0]       len_word;
  logic              timeout_hit;

  assign len_word = {cnt_hi_q, rx_bus.data};

`ifdef HACK_LOADER_TIMEOUT_EN
  localparam int unsigned     TO_W    = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CLKS - 1);

  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      to_cnt_q <= TO_LOAD;
    end else if (!in_frame(state_q) || rx_bus.byte_valid) begin
      to_cnt_q <= TO_LOAD;
    end else if (to_cnt_q != '0) begin
      to_cnt_q <= to_cnt_q - TO_W'(1);
    end
  end

  assign timeout_hit = in_frame(state_q) && (to_cnt_q == '0);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state_q      <= ST_IDLE;
      cnt_hi_q     <= '0;
      data_hi_q    <= '0;
      sum_q        <= '0;
      words_left_q <= '0;
      addr_q       <= '0;
      rom_data_q   <= '0;
      wr_q         <= 1'b0;
      hold_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      // Skipping the post-write increment on the last word keeps a full-depth load from wrapping.
      if (wr_q && (words_left_q != '0)) addr_q <= addr_q + ADDR_ONE;

      if (rx_bus.frame_err && in_frame(state_q)) begin
        state_q <= ST_ERROR;
        busy_q  <= 1'b0;
        error_q <= 1'b1;
        hold_q  <= 1'b1;
      end else if (rx_bus.byte_valid) begin
        unique case (state_q)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (rx_bus.data == HEADER_BYTE) begin
              state_q <= ST_LEN_HI;
              addr_q  <= '0;
              sum_q   <= '0;
              done_q  <= 1'b0;
              error_q <= 1'b0;
              busy_q  <= 1'b1;
              hold_q  <= 1'b1;
            end
          end
          ST_LEN_HI: begin
            cnt_hi_q <= rx_bus.data;
            sum_q    <= sum_q + rx_bus.data;
            state_q  <= ST_LEN_LO;
          end
          ST_LEN_LO: begin
            sum_q <= sum_q + rx_bus.data;
            if (count_ok(len_word, ADDR_W)) begin
              words_left_q <= len_word[ADDR_W:0];
              state_q      <= ST_DATA_HI;
            end else begin
              state_q <= ST_ERROR;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end
          end
          ST_DATA_HI: begin
            data_hi_q <= rx_bus.data;
            sum_q     <= sum_q + rx_bus.data;
            state_q   <= ST_DATA_LO;
          end
          ST_DATA_LO: begin
            rom_data_q   <= {data_hi_q, rx_bus.data};
            wr_q         <= 1'b1;
            sum_q        <= sum_q + rx_bus.data;
            words_left_q <= words_left_q - WORDS_ONE;
            state_q      <= (words_left_q == WORDS_ONE) ? ST_CHECK : ST_DATA_HI;
          end
          ST_CHECK: begin
            busy_q <= 1'b0;
            if (rx_bus.data == sum_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= ST_ERROR;
              error_q <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (timeout_hit) begin
        state_q <= ST_ERROR;
        busy_q  <= 1'b0;
        error_q <= 1'b1;
        hold_q  <= 1'b1;
      end
    end
  end

  assign o_ROM_Address  = addr_q;
  assign o_ROM_Data     = rom_data_q;
  assign o_ROM_Write_EN = wr_q;
  assign o_CPU_Hold     = hold_q;
  assign o_Busy         = busy_q;
  assign o_Done         = done_q;
  assign o_Error        = error_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed plus randomized frame tests for hack_rom_loader against a frame-level model.
module tb_hack_rom_loader;

  localparam int CPB = 4;
  localparam int AW  = 4;
  localparam int TO  = 50;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx    = 1'b1;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          wr_en;
  logic          hold;
  logic          busy;
  logic          done;
  logic          err;

  int          checks   = 0;
  int          failures = 0;
  logic [19:0] wr_log[$];
  logic        wr_prev  = 1'b0;
  logic [15:0] words[$];

  always #5 clk = ~clk;

  hack_rom_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .i_CLK         (clk),
    .i_RESET_n     (rst_n),
    .i_RX          (rx),
    .o_ROM_Address (rom_addr),
    .o_ROM_Data    (rom_data),
    .o_ROM_Write_EN(wr_en),
    .o_CPU_Hold    (hold),
    .o_Busy        (busy),
    .o_Done        (done),
    .o_Error       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: log every strobe and confirm it is a single-cycle pulse.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      check("write_strobe_single_cycle", {31'd0, wr_prev}, 32'd0);
      wr_log.push_back({rom_addr, rom_data});
    end
    wr_prev = (wr_en === 1'b1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop_bit) repeat (2 * CPB) @(negedge clk);
  endtask

  // Sends header, count, words and a checksum offset by chk_delta (0 = correct).
  task automatic send_frame(input logic [15:0] cnt, input logic [15:0] w[$], input logic [7:0] chk_delta);
    logic [7:0] s;
    s = cnt[15:8] + cnt[7:0];
    send_byte(8'hA5, 1'b1);
    send_byte(cnt[15:8], 1'b1);
    send_byte(cnt[7:0], 1'b1);
    foreach (w[i]) begin
      send_byte(w[i][15:8], 1'b1);
      send_byte(w[i][7:0], 1'b1);
      s = s + w[i][15:8] + w[i][7:0];
    end
    send_byte(s + chk_delta, 1'b1);
  endtask

  task automatic check_writes(input string tag, input logic [15:0] w[$]);
    check({tag, " write_count"}, wr_log.size(), w.size());
    foreach (w[i]) begin
      if (i < wr_log.size()) check({tag, " write_addr_data"}, {12'd0, wr_log[i]}, {12'd0, AW'(i), w[i]});
    end
  endtask

  task automatic check_status(input string tag, input logic [3:0] exp);
    check({tag, " hold_busy_done_err"}, {28'd0, hold, busy, done, err}, {28'd0, exp});
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          fall_k;
    int          done_k;
    int          n;
    bit          good;
    logic [7:0]  delta;
    logic [7:0]  junk;

    // Reset values
    idle(3);
    check("reset outputs", {7'd0, rom_addr, rom_data, wr_en, hold, busy, done, err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(3);

    // Non-header bytes in IDLE are ignored
    wr_log.delete();
    send_byte(8'h55, 1'b1);
    send_byte(8'h3C, 1'b1);
    idle(6);
    check_status("idle_junk", 4'b0000);
    check("idle_junk write_count", wr_log.size(), 0);

    // Header with a bad stop bit in IDLE is discarded
    send_byte(8'hA5, 1'b0);
    idle(6);
    check_status("idle_bad_stop_header", 4'b0000);

    // Frame A: good checksum; hold release coincides with done
    wr_log.delete();
    words.delete();
    words.push_back(16'h1234);
    words.push_back(16'hABCD);
    send_frame(16'd2, words, 8'd0);
    fall_k = 0;
    done_k = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (fall_k == 0 && hold === 1'b0) fall_k = k;
      if (done_k == 0 && done === 1'b1) done_k = k;
    end
    check("A hold_release_seen", {31'd0, fall_k != 0}, 32'd1);
    check("A hold_release_cycle_vs_done", fall_k, done_k);
    check_writes("A", words);
    check_status("A", 4'b0010);

    // Frame A with bad checksum: writes still happen, hold stays up
    wr_log.delete();
    send_frame(16'd2, words, 8'd1);
    idle(6);
    check_writes("A_badchk", words);
    check_status("A_badchk", 4'b1001);
    send_byte(8'h3C, 1'b1);
    idle(20);
    check_status("A_badchk_after_junk", 4'b1001);

    // Header clears sticky error; COUNT=0 aborts without writes
    wr_log.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(4);
    check_status("count0 mid_header", 4'b1100);
    send_byte(8'h00, 1'b1);
    idle(6);
    check_status("count0", 4'b1001);
    check("count0 write_count", wr_log.size(), 0);

    // COUNT=17 exceeds depth 16
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    idle(6);
    check_status("count17", 4'b1001);
    check("count17 write_count", wr_log.size(), 0);

    // Full-depth image
    wr_log.delete();
    words.delete();
    for (int i = 0; i < 16; i++) words.push_back(16'($urandom));
    send_frame(16'd16, words, 8'd0);
    idle(6);
    check_writes("full_depth", words);
    check_status("full_depth", 4'b0010);

    // Randomized frames
    for (int f = 0; f < 5; f++) begin
      n    = $urandom_range(1, 16);
      good = ($urandom_range(0, 2) != 0);
      delta = good ? 8'd0 : 8'($urandom_range(1, 255));
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
      wr_log.delete();
      send_frame(16'(n), words, delta);
      idle(6);
      check_writes("random", words);
      check_status("random", good ? 4'b0010 : 4'b1001);
      junk = 8'($urandom_range(0, 255));
      if (junk == 8'hA5) junk = 8'h5A;
      send_byte(junk, 1'b1);
      idle(6);
      check_status("random after_junk", good ? 4'b0010 : 4'b1001);
    end

    // Reset after first word: asynchronous clear, then reload from address 0
    wr_log.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    idle(4);
    check("midload write_count", wr_log.size(), 1);
    check("midload rom_data", {16'd0, rom_data}, 32'h1234);
    check_status("midload", 4'b1100);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset outputs", {7'd0, rom_addr, rom_data, wr_en, hold, busy, done, err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(3);
    wr_log.delete();
    words.delete();
    words.push_back(16'h1234);
    words.push_back(16'hABCD);
    send_frame(16'd2, words, 8'd0);
    idle(6);
    check_writes("reload", words);
    check_status("reload", 4'b0010);

    // Stall after COUNT_LO, then a framing error mid-frame
    wr_log.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    idle(64);
`ifdef HACK_LOADER_TIMEOUT_EN
    check_status("stall timeout", 4'b1001);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
`else
    check_status("stall waiting", 4'b1100);
`endif
    send_byte(8'h34, 1'b0);
    idle(6);
    check_status("frame_error", 4'b1001);
    check("frame_error write_count", wr_log.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
